// File: rtl/ternary_word_seq.sv
// ============================================================================
// Module   : ternary_word_seq
// Function : Serial word-wide front end for the trit ops (min/max/any/consensus),
//            one trit per cycle LSB first. Option macro: TERNARY_INVALID_CHECK_EN
// Revision : 1.0
// ============================================================================
`default_nettype none

module ternary_word_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] in_a,
  input  logic [2*N-1:0] in_b,
  input  logic [1:0]     in_op,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_result,
  output logic           out_err
);

  localparam int          c_CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [1:0]  c_T_MINUS  = 2'b00;
  localparam logic [1:0]  c_T_ZERO   = 2'b01;
  localparam logic [1:0]  c_T_PLUS   = 2'b10;
  localparam logic [1:0]  c_OP_MIN   = 2'b00;
  localparam logic [1:0]  c_OP_MAX   = 2'b01;
  localparam logic [1:0]  c_OP_ANY   = 2'b10;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state, w_next;
  logic [2*N-1:0]  r_a, r_b, r_result;
  logic [1:0]      r_op;
  logic [c_CW-1:0] r_cnt;
  logic            w_capture;
  logic            w_last;
  logic [1:0]      w_ta, w_tb, w_trit;
  logic            w_pa, w_na, w_pb, w_nb;
  logic            w_pos, w_neg;

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign out_result = r_result;
  assign w_capture  = in_valid && in_ready;
  assign w_last     = (r_cnt == c_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_capture) w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Only the codes 10 and 00 carry a sign; 01 and the invalid 11 both read as zero.
  assign w_ta = r_a[{r_cnt, 1'b0} +: 2];
  assign w_tb = r_b[{r_cnt, 1'b0} +: 2];
  assign w_pa = (w_ta == c_T_PLUS);
  assign w_na = (w_ta == c_T_MINUS);
  assign w_pb = (w_tb == c_T_PLUS);
  assign w_nb = (w_tb == c_T_MINUS);

  always_comb begin
    w_pos = 1'b0;
    w_neg = 1'b0;
    case (r_op)
      c_OP_MIN: begin
        w_neg = w_na | w_nb;
        w_pos = w_pa & w_pb;
      end
      c_OP_MAX: begin
        w_pos = w_pa | w_pb;
        w_neg = w_na & w_nb;
      end
      c_OP_ANY: begin
        w_pos = (w_pa | w_pb) & ~(w_na | w_nb);
        w_neg = (w_na | w_nb) & ~(w_pa | w_pb);
      end
      default: begin
        w_pos = w_pa & w_pb;
        w_neg = w_na & w_nb;
      end
    endcase
  end

  always_comb begin
    w_trit = c_T_ZERO;
    if (w_pos)      w_trit = c_T_PLUS;
    else if (w_neg) w_trit = c_T_MINUS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
      r_result <= {N{c_T_ZERO}};
    end else if (w_capture) begin
      r_a      <= in_a;
      r_b      <= in_b;
      r_op     <= in_op;
      r_cnt    <= '0;
      r_result <= {N{c_T_ZERO}};
    end else if (r_state == S_RUN) begin
      r_result[{r_cnt, 1'b0} +: 2] <= w_trit;
      if (!w_last) r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef TERNARY_INVALID_CHECK_EN
  logic r_err;
  logic w_bad;

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (in_a[2*i +: 2] == 2'b11 || in_b[2*i +: 2] == 2'b11) w_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_err <= 1'b0;
    else if (w_capture) r_err <= w_bad;
  end

  assign out_err = r_err;
`else
  assign out_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ternary_word_seq.sv
// Directed self-checking bench for ternary_word_seq at N=4.
`default_nettype none

module tb_ternary_word_seq;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] in_a, in_b;
  logic [1:0]     in_op;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] out_result;
  logic           out_err;

  int n_cmp = 0;
  int n_err = 0;

`ifdef TERNARY_INVALID_CHECK_EN
  localparam logic c_ERR_ON_BAD = 1'b1;
`else
  localparam logic c_ERR_ON_BAD = 1'b0;
`endif

  ternary_word_seq #(.N(N)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic finish_op(input string tag, input int cyc, input logic [7:0] exp_res,
                           input logic exp_err);
    chk({tag, "_lat"}, 32'(cyc), 32'(N));
    chk({tag, "_res"}, 32'(out_result), 32'(exp_res));
    chk({tag, "_err"}, 32'(out_err), 32'(exp_err));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
    chk({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
  endtask

  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] op, input logic [7:0] exp_res, input logic exp_err);
    int cyc;
    start_op(a, b, op);
    wait_done(cyc);
    finish_op(tag, cyc, exp_res, exp_err);
  endtask

  initial begin
    int  cyc;
    logic seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(out_result), 32'h55);
    chk("rst_err", 32'(out_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("min", 8'b10101010, 8'b00000000, 2'b00, 8'b00000000, 1'b0);
    do_op("max", 8'b10101010, 8'b00000000, 2'b01, 8'b10101010, 1'b0);
    do_op("any", 8'b10010010, 8'b10000100, 2'b10, 8'b10000001, 1'b0);
    do_op("cons", 8'b10010010, 8'b10000100, 2'b11, 8'b10010101, 1'b0);
    do_op("bad", 8'b11101010, 8'b10101010, 2'b11, 8'b01101010, c_ERR_ON_BAD);
    // err must clear on the next clean capture
    do_op("clean", 8'b01010101, 8'b10101010, 2'b01, 8'b10101010, 1'b0);

    // back-pressure: DONE held with stable result while out_ready is low
    start_op(8'b10010010, 8'b10000100, 2'b10);
    wait_done(cyc);
    chk("bp_lat", 32'(cyc), 32'(N));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_result", 32'(out_result), 32'h81);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    finish_op("bp", N, 8'b10000001, 1'b0);

    // operands and opcode changed during RUN, with in_valid held high
    start_op(8'b10101010, 8'b00000000, 2'b01);
    in_valid = 1'b1;
    in_a     = 8'b00000000;
    in_b     = 8'b01010101;
    in_op    = 2'b00;
    wait_done(cyc);
    in_valid = 1'b0;
    finish_op("hold", cyc, 8'b10101010, 1'b0);

    // reset pulse in the second RUN cycle aborts the operation
    start_op(8'b10101010, 8'b10101010, 2'b11);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_result", 32'(out_result), 32'h55);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_emit", 32'(seen), 32'd0);
    chk("abort_result_after", 32'(out_result), 32'h55);

    do_op("post_rst", 8'b00100110, 8'b10011000, 2'b00, 8'b00010100, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
